// File: rtl/pipe_pkg.sv
// Shared types and default constants for the pipeline sequencer.
package pipe_pkg;

    localparam int PIPE_FLUSH_DEPTH = 4;
    localparam int PIPE_ADRX_W      = 5;
    localparam int PIPE_CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_LOAD_STALL = 3'd1,
        ST_FLUSH      = 3'd2,
        ST_HALT_INSN  = 3'd3,
        ST_HALT_DBG   = 3'd4,
        ST_STEP       = 3'd5
    } pipe_state_t;

endpackage

// File: rtl/pipe_sequencer_if.sv
// Hazard/branch/debug inputs and stage-control outputs of the sequencer.
interface pipe_sequencer_if
    import pipe_pkg::*;
#(
    parameter int ADRX_W = PIPE_ADRX_W,
    parameter int CNT_W  = PIPE_CNT_W
) ();
    logic              doBranch;
    logic              decodeHalt;
    logic [ADRX_W-1:0] decodeRfRdAdrx0;
    logic [ADRX_W-1:0] decodeRfRdAdrx1;
    logic              decodeUsesRd1;
    logic [ADRX_W-1:0] execRfWrAdrx;
    logic              execRfWriteEn;
    logic              execDmemResultSel;
    logic              debugHalt;
    logic              debugStep;
    logic              fetchEn;
    logic              decodeEn;
    logic              bubble;
    logic              squash;
    logic              halted;
    logic [CNT_W-1:0]  stallCount;
    logic [CNT_W-1:0]  flushCount;

    // pipeline control side: supplies hazard/branch/debug info
    modport master (
        output doBranch, decodeHalt, decodeRfRdAdrx0, decodeRfRdAdrx1,
               decodeUsesRd1, execRfWrAdrx, execRfWriteEn, execDmemResultSel,
               debugHalt, debugStep,
        input  fetchEn, decodeEn, bubble, squash, halted, stallCount, flushCount
    );

    // sequencer side
    modport slave (
        input  doBranch, decodeHalt, decodeRfRdAdrx0, decodeRfRdAdrx1,
               decodeUsesRd1, execRfWrAdrx, execRfWriteEn, execDmemResultSel,
               debugHalt, debugStep,
        output fetchEn, decodeEn, bubble, squash, halted, stallCount, flushCount
    );
endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in exec writing a register that decode reads.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int ADRX_W = PIPE_ADRX_W
) (
    input  logic [ADRX_W-1:0] rd_adrx0,
    input  logic [ADRX_W-1:0] rd_adrx1,
    input  logic              uses_rd1,
    input  logic [ADRX_W-1:0] wr_adrx,
    input  logic              wr_en,
    input  logic              is_load,
    output logic              hazard
);
    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign hazard = is_load & wr_en & (wr_adrx != '0) &
                    ((wr_adrx == rd_adrx0) | (uses_rd1 & (wr_adrx == rd_adrx1)));
endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: one FSM plus flush counter driving stage enables,
// bubble/squash, halt status and saturating stall/flush counters.
module pipe_sequencer
    import pipe_pkg::*;
#(
    parameter int FLUSH_DEPTH = PIPE_FLUSH_DEPTH,
    parameter int ADRX_W      = PIPE_ADRX_W,
    parameter int CNT_W       = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    pipe_sequencer_if.slave  pif
);
    // FLUSH covers the cycles after the doBranch cycle, which squashes on its own
    localparam logic [3:0] FLUSH_LOAD      = 4'(FLUSH_DEPTH - 1);
    localparam bit         FLUSH_ON_BRANCH = (FLUSH_DEPTH > 1);

    pipe_state_t      state;
    logic [3:0]       flush_cnt;
    logic             halted_q;
    logic             hazard;
    logic             fetch_en;
    logic             decode_en;
    logic             bubble_o;
    logic             squash_o;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    hazard_detect #(.ADRX_W(ADRX_W)) u_hazard (
        .rd_adrx0 (pif.decodeRfRdAdrx0),
        .rd_adrx1 (pif.decodeRfRdAdrx1),
        .uses_rd1 (pif.decodeUsesRd1),
        .wr_adrx  (pif.execRfWrAdrx),
        .wr_en    (pif.execRfWriteEn),
        .is_load  (pif.execDmemResultSel),
        .hazard   (hazard)
    );

    // sequencing FSM with flush counter and registered halt flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            halted_q  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pif.doBranch) begin
                        if (FLUSH_ON_BRANCH) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FLUSH_LOAD;
                        end
                    end else if (hazard) begin
                        state <= ST_LOAD_STALL;
                    end else if (pif.decodeHalt) begin
                        state    <= ST_HALT_INSN;
                        halted_q <= 1'b1;
                    end else if (pif.debugHalt) begin
                        state    <= ST_HALT_DBG;
                        halted_q <= 1'b1;
                    end
                end
                ST_LOAD_STALL: begin
                    if (pif.doBranch && FLUSH_ON_BRANCH) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (pif.doBranch) begin
                        flush_cnt <= FLUSH_LOAD;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                        if (flush_cnt <= 4'd1) state <= ST_RUN;
                    end
                end
                ST_HALT_INSN: ;
                ST_HALT_DBG: begin
                    if (pif.debugStep) begin
                        state    <= ST_STEP;
                        halted_q <= 1'b0;
                    end else if (!pif.debugHalt) begin
                        state    <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                ST_STEP: begin
                    // a stalled step keeps stepping until the instruction advances
                    if (!hazard) begin
                        if (pif.debugHalt) begin
                            state    <= ST_HALT_DBG;
                            halted_q <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Mealy stage controls from state and current hazard/branch inputs
    always_comb begin
        fetch_en  = 1'b1;
        decode_en = 1'b1;
        bubble_o  = 1'b0;
        case (state)
            ST_LOAD_STALL: begin
                fetch_en  = pif.doBranch;   // let the PC take a branch target
                decode_en = 1'b0;
                bubble_o  = 1'b1;
            end
            ST_HALT_INSN, ST_HALT_DBG: begin
                fetch_en  = 1'b0;
                decode_en = 1'b0;
            end
            ST_STEP: begin
                if (hazard) begin
                    fetch_en  = 1'b0;
                    decode_en = 1'b0;
                    bubble_o  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign squash_o = pif.doBranch | (state == ST_FLUSH);

    // saturating performance counters, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (bubble_o && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
            if (squash_o && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
        end
    end

    assign pif.fetchEn    = fetch_en;
    assign pif.decodeEn   = decode_en;
    assign pif.bubble     = bubble_o;
    assign pif.squash     = squash_o;
    assign pif.halted     = halted_q;
    assign pif.stallCount = stall_count;
    assign pif.flushCount = flush_count;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: directed scenarios plus a
// randomized run against a behavioural model of the sequencing rules.
module tb_pipe_sequencer;
    localparam int FD   = 4;
    localparam int AW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_sequencer_if #(.ADRX_W(AW), .CNT_W(CW)) pif ();

    pipe_sequencer #(.FLUSH_DEPTH(FD), .ADRX_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif)
    );

    // behavioural model: what the pipeline should be doing, not how
    int m_flush_rem;   // squash-only cycles still owed after a branch
    bit m_stall_now;   // this cycle is the single load-use stall cycle
    bit m_ihalt, m_dhalt, m_step;
    int m_sc, m_fc;
    bit e_fe, e_de, e_bub, e_sq, e_halt;

    function automatic bit model_hz();
        int wr, r0, r1;
        wr = int'(pif.execRfWrAdrx);
        r0 = int'(pif.decodeRfRdAdrx0);
        r1 = int'(pif.decodeRfRdAdrx1);
        return pif.execDmemResultSel && pif.execRfWriteEn && wr != 0 &&
               (wr == r0 || (pif.decodeUsesRd1 && wr == r1));
    endfunction

    function automatic void model_reset();
        m_flush_rem = 0; m_stall_now = 0; m_ihalt = 0; m_dhalt = 0; m_step = 0;
        m_sc = 0; m_fc = 0;
    endfunction

    function automatic void model_outputs();
        bit hz = model_hz();
        e_sq   = pif.doBranch || (m_flush_rem > 0);
        e_halt = m_ihalt || m_dhalt;
        if (m_ihalt || m_dhalt)   begin e_fe = 0; e_de = 0; e_bub = 0; end
        else if (m_stall_now)     begin e_fe = pif.doBranch; e_de = 0; e_bub = 1; end
        else if (m_step && hz)    begin e_fe = 0; e_de = 0; e_bub = 1; end
        else                      begin e_fe = 1; e_de = 1; e_bub = 0; end
    endfunction

    function automatic void model_advance();
        bit hz = model_hz();
        if (e_bub && m_sc < CMAX) m_sc++;
        if (e_sq && m_fc < CMAX)  m_fc++;
        if (m_ihalt) begin
        end else if (m_dhalt) begin
            if (pif.debugStep) begin m_dhalt = 0; m_step = 1; end
            else if (!pif.debugHalt) m_dhalt = 0;
        end else if (m_step) begin
            if (!hz) begin m_step = 0; m_dhalt = pif.debugHalt; end
        end else if (m_flush_rem > 0) begin
            m_flush_rem = pif.doBranch ? FD - 1 : m_flush_rem - 1;
        end else if (m_stall_now) begin
            m_stall_now = 0;
            if (pif.doBranch) m_flush_rem = FD - 1;
        end else begin
            if (pif.doBranch)        m_flush_rem = FD - 1;
            else if (hz)             m_stall_now = 1;
            else if (pif.decodeHalt) m_ihalt = 1;
            else if (pif.debugHalt)  m_dhalt = 1;
        end
    endfunction

    task automatic idle();
        pif.doBranch = 0; pif.decodeHalt = 0; pif.decodeRfRdAdrx0 = '0;
        pif.decodeRfRdAdrx1 = '0; pif.decodeUsesRd1 = 0; pif.execRfWrAdrx = '0;
        pif.execRfWriteEn = 0; pif.execDmemResultSel = 0;
        pif.debugHalt = 0; pif.debugStep = 0;
    endtask

    task automatic set_load(input int dst);
        pif.execDmemResultSel = 1; pif.execRfWriteEn = 1; pif.execRfWrAdrx = AW'(dst);
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 0; idle();
        nxt(); nxt();
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0; idle(); pif.doBranch = 1;
        nxt(); nxt(); #2;
        checks++; if (pif.fetchEn !== 1'b1)  begin errors++; $display("FAIL rst_fetchEn got=%b exp=1", pif.fetchEn); end
        checks++; if (pif.decodeEn !== 1'b1) begin errors++; $display("FAIL rst_decodeEn got=%b exp=1", pif.decodeEn); end
        checks++; if (pif.bubble !== 1'b0)   begin errors++; $display("FAIL rst_bubble got=%b exp=0", pif.bubble); end
        checks++; if (pif.halted !== 1'b0)   begin errors++; $display("FAIL rst_halted got=%b exp=0", pif.halted); end
        checks++; if (pif.squash !== 1'b1)   begin errors++; $display("FAIL rst_squash_br got=%b exp=1", pif.squash); end
        checks++; if (pif.flushCount !== '0) begin errors++; $display("FAIL rst_flushCount got=%0d exp=0", pif.flushCount); end
        checks++; if (pif.stallCount !== '0) begin errors++; $display("FAIL rst_stallCount got=%0d exp=0", pif.stallCount); end
        pif.doBranch = 0; #1;
        checks++; if (pif.squash !== 1'b0)   begin errors++; $display("FAIL rst_squash_nobr got=%b exp=0", pif.squash); end
        nxt(); reset = 1;
    endtask

    task automatic test_load_stall();
        do_reset();
        set_load(3); pif.decodeRfRdAdrx0 = AW'(3); #2;
        checks++; if (pif.fetchEn !== 1'b1) begin errors++; $display("FAIL ls_detect_fetchEn got=%b exp=1", pif.fetchEn); end
        nxt(); idle(); #2;
        checks++; if ({pif.fetchEn, pif.decodeEn, pif.bubble} !== 3'b001) begin errors++; $display("FAIL ls_stall_ctl got=%b exp=001", {pif.fetchEn, pif.decodeEn, pif.bubble}); end
        nxt(); #2;
        checks++; if ({pif.fetchEn, pif.decodeEn, pif.bubble} !== 3'b110) begin errors++; $display("FAIL ls_resume_ctl got=%b exp=110", {pif.fetchEn, pif.decodeEn, pif.bubble}); end
        checks++; if (pif.stallCount !== CW'(1)) begin errors++; $display("FAIL ls_stallCount got=%0d exp=1", pif.stallCount); end
        // load into r0 never stalls
        nxt(); set_load(0); pif.decodeRfRdAdrx0 = '0; #2; nxt(); idle(); #2;
        checks++; if (pif.bubble !== 1'b0) begin errors++; $display("FAIL ls_r0_bubble got=%b exp=0", pif.bubble); end
        // port-1 match only counts when decode actually reads port 1
        nxt(); set_load(7); pif.decodeRfRdAdrx1 = AW'(7); pif.decodeUsesRd1 = 0; #2; nxt(); idle(); #2;
        checks++; if (pif.bubble !== 1'b0) begin errors++; $display("FAIL ls_rd1_unused_bubble got=%b exp=0", pif.bubble); end
        nxt(); set_load(7); pif.decodeRfRdAdrx1 = AW'(7); pif.decodeUsesRd1 = 1; #2; nxt(); idle(); #2;
        checks++; if (pif.bubble !== 1'b1) begin errors++; $display("FAIL ls_rd1_used_bubble got=%b exp=1", pif.bubble); end
        nxt(); #2;
        checks++; if (pif.stallCount !== CW'(2)) begin errors++; $display("FAIL ls_stallCount2 got=%0d exp=2", pif.stallCount); end
    endtask

    task automatic test_branch();
        int n = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pif.doBranch = (i == 0); #2;
            if (pif.squash) n++;
            checks++; if (pif.squash !== (i < FD)) begin errors++; $display("FAIL br_squash cyc=%0d got=%b exp=%b", i, pif.squash, (i < FD)); end
            checks++; if (pif.fetchEn !== 1'b1) begin errors++; $display("FAIL br_fetchEn cyc=%0d got=%b exp=1", i, pif.fetchEn); end
            nxt();
        end
        #2;
        checks++; if (n != FD) begin errors++; $display("FAIL br_squash_len got=%0d exp=%0d", n, FD); end
        checks++; if (pif.flushCount !== CW'(FD)) begin errors++; $display("FAIL br_flushCount got=%0d exp=%0d", pif.flushCount, FD); end
    endtask

    task automatic test_branch_hazard();
        do_reset();
        pif.doBranch = 1; set_load(3); pif.decodeRfRdAdrx0 = AW'(3); #2;
        checks++; if ({pif.squash, pif.bubble} !== 2'b10) begin errors++; $display("FAIL bh_first got=%b exp=10", {pif.squash, pif.bubble}); end
        nxt(); idle();
        for (int i = 1; i < 6; i++) begin
            #2;
            checks++; if (pif.bubble !== 1'b0) begin errors++; $display("FAIL bh_bubble cyc=%0d got=%b exp=0", i, pif.bubble); end
            nxt();
        end
        #2;
        checks++; if (pif.stallCount !== '0) begin errors++; $display("FAIL bh_stallCount got=%0d exp=0", pif.stallCount); end
    endtask

    task automatic test_double_branch();
        int n = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pif.doBranch = (i == 0 || i == 2); #2;
            if (pif.squash) n++;
            checks++; if (pif.squash !== (i < 2 + FD)) begin errors++; $display("FAIL dbr_squash cyc=%0d got=%b exp=%b", i, pif.squash, (i < 2 + FD)); end
            nxt();
        end
        #2;
        checks++; if (n != 2 + FD) begin errors++; $display("FAIL dbr_squash_len got=%0d exp=%0d", n, 2 + FD); end
        checks++; if (pif.flushCount !== CW'(2 + FD)) begin errors++; $display("FAIL dbr_flushCount got=%0d exp=%0d", pif.flushCount, 2 + FD); end
    endtask

    task automatic test_debug_step();
        bit [9:0] dh_v, ds_v, fe_v, h_v;
        int n = 0;
        dh_v = 10'b0011111111; ds_v = 10'b0000100100;
        fe_v = 10'b1001001001; h_v  = 10'b0110110110;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pif.debugHalt = dh_v[i]; pif.debugStep = ds_v[i]; #2;
            if (i >= 1 && i <= 8 && pif.fetchEn) n++;
            checks++; if ({pif.fetchEn, pif.decodeEn} !== {fe_v[i], fe_v[i]}) begin errors++; $display("FAIL dbg_enables cyc=%0d got=%b exp=%b", i, {pif.fetchEn, pif.decodeEn}, {fe_v[i], fe_v[i]}); end
            checks++; if (pif.halted !== h_v[i]) begin errors++; $display("FAIL dbg_halted cyc=%0d got=%b exp=%b", i, pif.halted, h_v[i]); end
            nxt();
        end
        checks++; if (n != 2) begin errors++; $display("FAIL dbg_step_count got=%0d exp=2", n); end
    endtask

    task automatic test_insn_halt();
        do_reset();
        set_load(2); pif.decodeRfRdAdrx0 = AW'(2); #2; nxt(); idle(); #2; nxt();
        pif.doBranch = 1; #2; nxt(); idle(); repeat (4) nxt();
        pif.decodeHalt = 1; #2;
        checks++; if (pif.halted !== 1'b0) begin errors++; $display("FAIL ih_pre_halted got=%b exp=0", pif.halted); end
        nxt(); pif.decodeHalt = 0;
        for (int i = 0; i < 8; i++) begin
            pif.debugStep = i[0]; pif.debugHalt = i[1]; #2;
            checks++; if ({pif.halted, pif.fetchEn, pif.decodeEn} !== 3'b100) begin errors++; $display("FAIL ih_frozen cyc=%0d got=%b exp=100", i, {pif.halted, pif.fetchEn, pif.decodeEn}); end
            nxt();
        end
        #2;
        checks++; if (pif.flushCount !== CW'(FD) || pif.stallCount !== CW'(1)) begin errors++; $display("FAIL ih_counts got=%0d/%0d exp=%0d/1", pif.flushCount, pif.stallCount, FD); end
        idle(); reset = 0; #1;
        checks++; if ({pif.halted, pif.fetchEn, pif.decodeEn} !== 3'b011) begin errors++; $display("FAIL ih_reset_ctl got=%b exp=011", {pif.halted, pif.fetchEn, pif.decodeEn}); end
        checks++; if (pif.flushCount !== '0 || pif.stallCount !== '0) begin errors++; $display("FAIL ih_reset_counts got=%0d/%0d exp=0/0", pif.flushCount, pif.stallCount); end
        nxt(); reset = 1;
    endtask

    task automatic test_saturation();
        do_reset();
        pif.doBranch = 1; repeat (CMAX + 5) nxt();
        idle(); set_load(4); pif.decodeRfRdAdrx0 = AW'(4);
        repeat (2 * CMAX + 8) nxt();
        idle(); #2;
        checks++; if (pif.flushCount !== CW'(CMAX)) begin errors++; $display("FAIL sat_flushCount got=%0d exp=%0d", pif.flushCount, CMAX); end
        checks++; if (pif.stallCount !== CW'(CMAX)) begin errors++; $display("FAIL sat_stallCount got=%0d exp=%0d", pif.stallCount, CMAX); end
    endtask

    task automatic test_random();
        bit dh = 0;
        do_reset(); model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) dh = ~dh;
            pif.doBranch          = ($urandom_range(0, 7) == 0);
            pif.decodeHalt        = ($urandom_range(0, 149) == 0);
            pif.decodeRfRdAdrx0   = AW'($urandom_range(0, 3));
            pif.decodeRfRdAdrx1   = AW'($urandom_range(0, 3));
            pif.decodeUsesRd1     = 1'($urandom_range(0, 1));
            pif.execRfWrAdrx      = AW'($urandom_range(0, 3));
            pif.execRfWriteEn     = ($urandom_range(0, 3) != 0);
            pif.execDmemResultSel = 1'($urandom_range(0, 1));
            pif.debugHalt         = dh;
            pif.debugStep         = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 249) == 0) begin reset = 0; model_reset(); end
            #2;
            model_outputs();
            checks++; if (pif.fetchEn !== e_fe)   begin errors++; $display("FAIL rnd_fetchEn cyc=%0d got=%b exp=%b", c, pif.fetchEn, e_fe); end
            checks++; if (pif.decodeEn !== e_de)  begin errors++; $display("FAIL rnd_decodeEn cyc=%0d got=%b exp=%b", c, pif.decodeEn, e_de); end
            checks++; if (pif.bubble !== e_bub)   begin errors++; $display("FAIL rnd_bubble cyc=%0d got=%b exp=%b", c, pif.bubble, e_bub); end
            checks++; if (pif.squash !== e_sq)    begin errors++; $display("FAIL rnd_squash cyc=%0d got=%b exp=%b", c, pif.squash, e_sq); end
            checks++; if (pif.halted !== e_halt)  begin errors++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", c, pif.halted, e_halt); end
            checks++; if (pif.stallCount !== CW'(m_sc)) begin errors++; $display("FAIL rnd_stallCount cyc=%0d got=%0d exp=%0d", c, pif.stallCount, m_sc); end
            checks++; if (pif.flushCount !== CW'(m_fc)) begin errors++; $display("FAIL rnd_flushCount cyc=%0d got=%0d exp=%0d", c, pif.flushCount, m_fc); end
            if (!reset) begin
                nxt(); reset = 1;
            end else begin
                model_advance();
                nxt();
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_stall();
        test_branch();
        test_branch_hazard();
        test_double_branch();
        test_debug_step();
        test_insn_halt();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
